// File: rtl/audio_tone_sequencer_if.sv
// Control inputs and sample outputs between the tone sequencer and its consumers.
interface audio_tone_sequencer_if;
    logic        frame_tick;
    logic        enable;
    logic [15:0] sample;
    logic        sample_valid;
    logic [3:0]  step_index;
    logic        note_on;

    modport master (
        input  frame_tick,
        input  enable,
        output sample,
        output sample_valid,
        output step_index,
        output note_on
    );

    modport slave (
        output frame_tick,
        output enable,
        input  sample,
        input  sample_valid,
        input  step_index,
        input  note_on
    );
endinterface

// File: rtl/audio_tone_sequencer.sv
// Single-voice sawtooth tone source for the PDM stage. It steps a fixed 16-entry
// note/rest pattern on frame ticks, and a decaying envelope shapes each note.
module audio_tone_sequencer #(
    parameter int SAMPLE_DIV  = 256,
    parameter int STEP_FRAMES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    audio_tone_sequencer_if.master bus
);
    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(STEP_FRAMES - 1);

    logic [DW-1:0] div_q, div_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [3:0]    step_q, step_d;
    logic [15:0]   phase_q, phase_d;
    logic [7:0]    env_q, env_d;
    logic [15:0]   sample_q, sample_d;
    logic          valid_q, valid_d;

    logic          tick_s;
    logic          adv;
    logic [3:0]    inc_mult;
    logic [15:0]   inc;
    logic [3:0]    step_nxt;

    always_comb begin
        tick_s   = bus.enable && (div_q == DIV_LAST);
        adv      = bus.enable && bus.frame_tick && (fcnt_q == FCNT_LAST);
        // Even steps are notes with increments 0x0100..0x0800; odd steps are rests.
        inc_mult = {1'b0, step_q[3:1]} + 4'd1;
        inc      = step_q[0] ? 16'h0000 : {4'h0, inc_mult, 8'h00};
        step_nxt = step_q + 4'd1;

        div_d    = div_q;
        fcnt_d   = fcnt_q;
        step_d   = step_q;
        phase_d  = phase_q;
        env_d    = env_q;
        sample_d = sample_q;
        valid_d  = tick_s;

        if (bus.enable) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end

        if (tick_s) begin
            sample_d = {8'h00, phase_q[15:8]} * {8'h00, env_q};
            phase_d  = phase_q + inc;
            env_d    = (env_q == 8'h00) ? 8'h00 : env_q - 8'h01;
        end else if (!bus.enable) begin
            sample_d = 16'h0000;
        end

        if (bus.enable && bus.frame_tick) begin
            fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + FW'(1);
        end

        // A step advance reloads the voice and wins over a coincident tick update.
        if (adv) begin
            step_d  = step_nxt;
            phase_d = 16'h0000;
            env_d   = step_nxt[0] ? 8'h00 : 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            fcnt_q   <= '0;
            step_q   <= 4'd0;
            phase_q  <= 16'h0000;
            env_q    <= 8'hFF;
            sample_q <= 16'h0000;
            valid_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            fcnt_q   <= fcnt_d;
            step_q   <= step_d;
            phase_q  <= phase_d;
            env_q    <= env_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.step_index   = step_q;
    assign bus.note_on      = ~step_q[0];
endmodule

// File: tb/tb_audio_tone_sequencer.sv
// Bench for audio_tone_sequencer: reference-model scoreboard on every sample pulse,
// a table of step-advance vectors, and hand sequences for multi-cycle corners.
module tb_audio_tone_sequencer;
    localparam int SAMPLE_DIV  = 4;
    localparam int STEP_FRAMES = 2;

    logic clk;
    logic rst;

    audio_tone_sequencer_if tif ();

    audio_tone_sequencer #(
        .SAMPLE_DIV  (SAMPLE_DIV),
        .STEP_FRAMES (STEP_FRAMES)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic [15:0] v;
    } sb_t;

    typedef struct {
        logic ft;
        int   idle;
        int   exp_step;
        logic exp_note;
    } vec_t;

    sb_t         sb[$];
    vec_t        tbl[31];
    logic [15:0] inc_rom[16];

    int          n_vec;
    int          n_err;
    int          edge_no;

    int          m_div;
    int          m_fcnt;
    int          m_step;
    logic [15:0] m_phase;
    logic [7:0]  m_env;

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    task automatic model(input logic r, input logic en, input logic ft);
        logic tk;
        logic ad;
        sb_t  x;
        if (r) begin
            m_div   = 0;
            m_fcnt  = 0;
            m_step  = 0;
            m_phase = 16'h0000;
            m_env   = 8'hFF;
        end else begin
            tk = en && (m_div == SAMPLE_DIV - 1);
            ad = en && ft && (m_fcnt == STEP_FRAMES - 1);
            if (tk) begin
                x.e = edge_no;
                x.v = {8'h00, m_phase[15:8]} * {8'h00, m_env};
                sb.push_back(x);
                m_phase = m_phase + inc_rom[m_step];
                m_env   = (m_env == 8'h00) ? 8'h00 : m_env - 8'h01;
            end
            if (en) m_div = (m_div + 1) % SAMPLE_DIV;
            if (en && ft) m_fcnt = (m_fcnt + 1) % STEP_FRAMES;
            if (ad) begin
                m_step  = (m_step + 1) % 16;
                m_phase = 16'h0000;
                m_env   = (m_step % 2 == 0) ? 8'hFF : 8'h00;
            end
        end
    endtask

    // One clock: drive, let the edge happen, update the model, then score outputs.
    task automatic cyc1(input logic r, input logic en, input logic ft);
        sb_t x;
        rst            = r;
        tif.enable     = en;
        tif.frame_tick = ft;
        @(posedge clk);
        edge_no++;
        model(r, en, ft);
        #1;
        n_vec++;
        if (sb.size() > 0 && sb[0].e == edge_no) begin
            x = sb.pop_front();
            if (!tif.sample_valid || tif.sample !== x.v) begin
                n_err++;
                $display("FAIL sb_sample edge %0d: valid=%b sample=0x%h, required valid=1 sample=0x%h",
                         edge_no, tif.sample_valid, tif.sample, x.v);
            end
        end else if (tif.sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sb_spurious edge %0d: valid=%b sample=0x%h, required valid=0",
                     edge_no, tif.sample_valid, tif.sample);
        end
    endtask

    task automatic do_reset();
        cyc1(1'b1, 1'b0, 1'b0);
        cyc1(1'b1, 1'b0, 1'b0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc1(1'b0, 1'b1, 1'b0);
    endtask

    task automatic wait_valid(output logic [15:0] s);
        bit found;
        found = 1'b0;
        s     = 16'h0000;
        for (int k = 0; k < 64 && !found; k++) begin
            cyc1(1'b0, 1'b1, 1'b0);
            if (tif.sample_valid === 1'b1) begin
                found = 1'b1;
                s     = tif.sample;
            end
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_valid: no sample_valid within 64 cycles, required a pulse");
        end
    endtask

    function automatic int saw(input int ph_hi, input int env);
        return (ph_hi & 255) * ((env < 0) ? 0 : env);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        n_vec   = 0;
        n_err   = 0;
        edge_no = 0;
        rst            = 1'b1;
        tif.enable     = 1'b0;
        tif.frame_tick = 1'b0;
        for (int k = 0; k < 16; k++)
            inc_rom[k] = (k % 2 == 0) ? 16'((k / 2 + 1) * 256) : 16'h0000;
        for (int i = 0; i < 31; i++) begin
            tbl[i].ft       = 1'b1;
            tbl[i].idle     = 3;
            tbl[i].exp_step = (i + 1) / 2;
            tbl[i].exp_note = (((i + 1) / 2) % 2 == 0);
        end

        // Reset state and basic output timing/values.
        do_reset();
        chk("rst_sample", tif.sample, 0);
        chk("rst_valid", tif.sample_valid, 0);
        chk("rst_step", tif.step_index, 0);
        chk("rst_note", tif.note_on, 1);
        run(3);
        chk("basic_no_early_valid", tif.sample_valid, 0);
        run(1);
        chk("basic_v1", tif.sample_valid, 1);
        chk("basic_s1", tif.sample, 16'h0000);
        run(4);
        chk("basic_v2", tif.sample_valid, 1);
        chk("basic_s2", tif.sample, 16'h00FE);
        run(4);
        chk("basic_v3", tif.sample_valid, 1);
        chk("basic_s3", tif.sample, 16'h01FA);

        // Step advance table: one frame_tick per record, two per step.
        do_reset();
        for (int i = 0; i < 31; i++) begin
            cyc1(1'b0, 1'b1, tbl[i].ft);
            chk($sformatf("tbl%0d_step", i), tif.step_index, tbl[i].exp_step);
            chk($sformatf("tbl%0d_note", i), tif.note_on, tbl[i].exp_note);
            run(tbl[i].idle);
        end
        cyc1(1'b0, 1'b1, 1'b1);
        chk("wrap_step", tif.step_index, 0);
        chk("wrap_note", tif.note_on, 1);
        wait_valid(s);
        chk("wrap_s0", s, 16'h0000);
        wait_valid(s);
        chk("wrap_s1", s, 16'h00FE);

        // Rest step emits zeros at the normal rate.
        do_reset();
        cyc1(1'b0, 1'b1, 1'b1);
        cyc1(1'b0, 1'b1, 1'b1);
        chk("rest_note", tif.note_on, 0);
        for (int j = 0; j < 3; j++) begin
            wait_valid(s);
            chk($sformatf("rest_s%0d", j), s, 0);
        end

        // Step 14: increment 0x0800, phase high byte wraps after 32 ticks.
        do_reset();
        for (int i = 0; i < 28; i++) cyc1(1'b0, 1'b1, 1'b1);
        chk("s14_step", tif.step_index, 14);
        for (int j = 0; j <= 32; j++) begin
            wait_valid(s);
            chk($sformatf("s14_j%0d", j), s, saw(8 * j, 255 - j));
        end

        // Envelope saturation over 300 ticks at step 0.
        do_reset();
        for (int j = 0; j < 300; j++) begin
            wait_valid(s);
            chk($sformatf("sat_j%0d", j), s, saw(j, 255 - j));
        end
        chk("sat_note", tif.note_on, 1);
        chk("sat_step", tif.step_index, 0);

        // Enable freeze with frame ticks during the gap.
        do_reset();
        for (int j = 0; j < 10; j++) wait_valid(s);
        cyc1(1'b0, 1'b0, 1'b0);
        chk("frz_sample0", tif.sample, 0);
        chk("frz_valid0", tif.sample_valid, 0);
        for (int k = 0; k < 1000; k++) cyc1(1'b0, 1'b0, (k % 50 == 0));
        chk("frz_step", tif.step_index, 0);
        chk("frz_sample", tif.sample, 0);
        cyc1(1'b0, 1'b1, 1'b0);
        chk("frz_resume_zero", tif.sample, 0);
        wait_valid(s);
        chk("frz_resume_s", s, saw(10, 245));
        for (int i = 0; i < 4; i++) cyc1(1'b0, 1'b1, 1'b1);
        chk("frz_fcnt_held", tif.step_index, 2);

        // Collisions: step advance on a tick edge.
        do_reset();
        for (int j = 0; j < 5; j++) wait_valid(s);
        cyc1(1'b0, 1'b1, 1'b1);
        run(2);
        cyc1(1'b0, 1'b1, 1'b1);
        chk("col0_valid", tif.sample_valid, 1);
        chk("col0_sample", tif.sample, saw(5, 250));
        chk("col0_step", tif.step_index, 1);
        wait_valid(s);
        chk("col0_next", s, 0);
        cyc1(1'b0, 1'b1, 1'b1);
        run(2);
        cyc1(1'b0, 1'b1, 1'b1);
        chk("col1_valid", tif.sample_valid, 1);
        chk("col1_sample", tif.sample, 0);
        chk("col1_step", tif.step_index, 2);
        wait_valid(s);
        chk("col1_next0", s, 16'h0000);
        wait_valid(s);
        chk("col1_next1", s, 16'h01FC);

        // Reset mid-operation at step 5, overriding enable and frame_tick.
        do_reset();
        for (int i = 0; i < 10; i++) cyc1(1'b0, 1'b1, 1'b1);
        chk("r5_step", tif.step_index, 5);
        run(5);
        cyc1(1'b1, 1'b1, 1'b1);
        chk("r5_sample", tif.sample, 0);
        chk("r5_valid", tif.sample_valid, 0);
        chk("r5_step_rst", tif.step_index, 0);
        chk("r5_note", tif.note_on, 1);
        wait_valid(s);
        chk("r5_s0", s, 16'h0000);
        wait_valid(s);
        chk("r5_s1", s, 16'h00FE);

        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
